// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared types, key codes and the byte-to-key decode table for
//                the serial keyboard receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4,
        ST_DECODE = 3'd5
    } spart_state_e;

    localparam logic [4:0] KEY_UP    = 5'h01;
    localparam logic [4:0] KEY_DOWN  = 5'h02;
    localparam logic [4:0] KEY_LEFT  = 5'h04;
    localparam logic [4:0] KEY_RIGHT = 5'h08;
    localparam logic [4:0] KEY_FIRE  = 5'h10;

    localparam logic [7:0] ASCII_W     = 8'h77;
    localparam logic [7:0] ASCII_S     = 8'h73;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_D     = 8'h64;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef struct packed {
        logic       valid;
        logic [4:0] key;
    } spart_key_t;

    // Upper-case letters fold to lower case; other bytes (including space) pass untouched.
    function automatic spart_key_t spart_decode(input logic [7:0] b);
        logic [7:0] lc;
        spart_key_t r;
        lc      = ((b >= 8'h41) && (b <= 8'h5A)) ? (b | 8'h20) : b;
        r.valid = 1'b1;
        r.key   = 5'h00;
        case (lc)
            ASCII_W:     r.key = KEY_UP;
            ASCII_S:     r.key = KEY_DOWN;
            ASCII_A:     r.key = KEY_LEFT;
            ASCII_D:     r.key = KEY_RIGHT;
            ASCII_SPACE: r.key = KEY_FIRE;
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_key_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spart_key_rx_if
//  Description : SPART key interface; receiver is the master, cpu the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface spart_key_rx_if;
    logic       SPART_we;
    logic [4:0] SPART_keys;

    modport master (output SPART_we, output SPART_keys);
    modport slave  (input  SPART_we, input  SPART_keys);
endinterface
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spart_baud_gen
//  Description : Oversample tick generator, one-cycle pulse every BAUD_DIV clks.
//  Revision    : 1.0  initial release
// ============================================================================
module spart_baud_gen #(
    parameter int BAUD_DIV = 27
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  restart,
    output logic tick
);
    localparam int            CW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Held in restart while idle, so the first tick lands BAUD_DIV clks after the start edge.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
            tick  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            tick  <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/spart_key_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spart_key_rx
//  Description : 8N1 UART receiver decoding keyboard bytes into one-hot keys.
//  Revision    : 1.0  initial release
// ============================================================================
module spart_key_rx
    import spart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               rxd,
    spart_key_rx_if.master    key_if,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);
    localparam int            TW          = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] c_half_last = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_full_last = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_START  = 3'(ST_START);
    localparam logic [2:0] S_DATA   = 3'(ST_DATA);
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
    localparam logic [2:0] S_BREAK  = 3'(ST_BREAK);
    localparam logic [2:0] S_DECODE = 3'(ST_DECODE);

    logic [2:0]    r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;

    logic          w_tick;
    logic          w_stop_sample;
    logic          w_err_inc;
    spart_key_t    w_dec;

    spart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (r_state == S_IDLE),
        .tick    (w_tick)
    );

    assign w_dec         = spart_decode(r_shift);
    assign w_stop_sample = (r_state == S_STOP) && w_tick && (r_tick_cnt == c_full_last);
    // Framing errors and unmapped bytes come from different states, so one increment per cycle suffices.
    assign w_err_inc     = (w_stop_sample && !r_sync2) || ((r_state == S_DECODE) && !w_dec.valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_sync1           <= 1'b1;
            r_sync2           <= 1'b1;
            r_tick_cnt        <= '0;
            r_bit_cnt         <= '0;
            r_shift           <= '0;
            key_if.SPART_we   <= 1'b0;
            key_if.SPART_keys <= 5'h00;
            frame_err         <= 1'b0;
        end else begin
            r_sync1         <= rxd;
            r_sync2         <= r_sync1;
            key_if.SPART_we <= 1'b0;
            frame_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_half_last) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= r_sync2 ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_full_last) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_sync2, r_shift[7:1]};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_full_last) begin
                            r_tick_cnt <= '0;
                            if (r_sync2) begin
                                r_state <= S_DECODE;
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= S_BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_BREAK: begin
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DECODE: begin
                    if (w_dec.valid) begin
                        key_if.SPART_we   <= 1'b1;
                        key_if.SPART_keys <= w_dec.key;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (w_err_inc && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spart_key_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_key_rx
//  Description : Self-checking bench for spart_key_rx against a byte-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spart_key_rx;
    localparam int BAUD_DIV   = 2;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = BAUD_DIV * OVERSAMPLE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       frame_err;
    logic [7:0] err_cnt;

    spart_key_rx_if kif ();

    spart_key_rx #(
        .BAUD_DIV   (BAUD_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .key_if    (kif),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];
    int   exp_err  = 0;
    int   exp_keys = 0;
    int   fe_seen  = 0;
    int   strobes  = 0;
    logic prev_we  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Key bit i belongs to the i-th character of this list; letters are case-insensitive.
    function automatic int ref_key(input logic [7:0] b);
        string      keys_str;
        logic [7:0] c;
        keys_str = "wsad ";
        c        = b;
        if (c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
        for (int i = 0; i < 5; i++) begin
            if (c == keys_str[i]) return (1 << i);
        end
        return 0;
    endfunction

    function automatic void model_err();
        if (exp_err < 255) exp_err++;
    endfunction

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        int k;
        k = ref_key(b);
        if (!stop) model_err();
        else if (k != 0) begin
            exp_q.push_back(k);
            exp_keys = k;
        end else model_err();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic end_scenario(input string tag);
        idle(40);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_keys"}, kif.SPART_keys, exp_keys);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (kif.SPART_we) begin
                strobes++;
                chk("we_single_cycle", prev_we, 0);
                if (exp_q.size() == 0) chk("we_unexpected", 1, 0);
                else chk("strobe_key", kif.SPART_keys, exp_q.pop_front());
            end
            if (frame_err) fe_seen++;
        end
        prev_we = kif.SPART_we;
    end

    initial begin
        int    s0;
        int    f0;
        int    e0;
        int    n_rand;
        string mapped;
        logic [7:0] b;
        logic [7:0] w_byte;
        mapped = "wsadWSAD ";

        repeat (5) @(negedge clk);
        chk("rst_we", kif.SPART_we, 0);
        chk("rst_keys", kif.SPART_keys, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        idle(10);

        s0 = strobes;
        send_byte(8'h77, 1'b1);
        end_scenario("w");
        chk("w_strobes", strobes - s0, 1);

        s0 = strobes;
        send_byte(8'h53, 1'b1);
        send_byte(8'h61, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h20, 1'b1);
        end_scenario("b2b");
        chk("b2b_strobes", strobes - s0, 4);

        s0 = strobes;
        f0 = fe_seen;
        send_byte(8'h41, 1'b0);
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        idle(60);
        end_scenario("break");
        chk("break_frame_err", fe_seen - f0, 1);
        chk("break_strobes", strobes - s0, 0);
        chk("break_err_is_one", err_cnt, 1);

        s0 = strobes;
        send_byte(8'h7A, 1'b1);
        end_scenario("z");
        chk("z_strobes", strobes - s0, 0);

        s0 = strobes;
        e0 = exp_err;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(60);
        chk("glitch_strobes", strobes - s0, 0);
        chk("glitch_err_cnt", err_cnt, e0);
        send_byte(8'h61, 1'b1);
        end_scenario("after_glitch");

        s0 = strobes;
        w_byte = 8'h77;
        drive_bit(1'b0);
        drive_bit(w_byte[0]);
        rst = 1'b1;
        for (int i = 1; i < 8; i++) drive_bit(w_byte[i]);
        chk("midrst_we", kif.SPART_we, 0);
        chk("midrst_keys", kif.SPART_keys, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        drive_bit(1'b1);
        rst = 1'b0;
        exp_q.delete();
        exp_err  = 0;
        exp_keys = 0;
        idle(60);
        chk("midrst_strobes", strobes - s0, 0);
        send_byte(8'h64, 1'b1);
        end_scenario("after_rst");
        chk("after_rst_key_d", kif.SPART_keys, 8'h08);

        n_rand = 24;
        for (int n = 0; n < n_rand; n++) begin
            if ($urandom_range(0, 2) != 0) b = mapped[$urandom_range(0, 8)];
            else b = 8'($urandom);
            send_byte(b, 1'b1);
            idle($urandom_range(0, 20));
        end
        end_scenario("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
